uart_word_tx: RTL and testbench

//   Parametrised UART transmitter for multi-byte words; successor to the fixed 32-bit/byte-mode serializer.

---
 rtl/uart_word_tx_if.sv | 26 ++
 rtl/uart_word_tx.sv | 207 ++++++++++++++++++++
 tb/tb_uart_word_tx.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_tx_if.sv
// Handshake and line bundle for the multi-byte UART transmitter.
// The word source drives valid/len/word; the transmitter answers with ready,
// the serial line and its busy/done status.
interface uart_word_tx_if #(
   parameter int WORD_BYTES = 4
) ();
   localparam int LW = $clog2(WORD_BYTES + 1);

   logic                    i_valid;
   logic [LW-1:0]           i_len;
   logic [8*WORD_BYTES-1:0] i_word;
   logic                    o_ready;
   logic                    o_serial;
   logic                    o_busy;
   logic                    o_done;

   modport master (
      output i_valid, i_len, i_word,
      input  o_ready, o_serial, o_busy, o_done
   );

   modport slave (
      input  i_valid, i_len, i_word,
      output o_ready, o_serial, o_busy, o_done
   );
endinterface

// File: rtl/uart_word_tx.sv
// Multi-byte UART transmitter: accepts a word of up to WORD_BYTES bytes plus a
// byte count and sends that many 8N1 (or 8N2) frames, LSB of each byte first.
// Byte order is selectable and an optional idle gap separates the bytes of one
// word.  Defining UART_TX_PARITY_EN inserts an even-parity bit after bit 7 of
// every frame; the port list is the same either way.
module uart_word_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int WORD_BYTES   = 4,
   parameter int STOP_BITS    = 1,
   parameter int GAP_BITS     = 0,
   parameter int MSB_BYTE_1ST = 0
) (
   input logic           sys_clk,
   input logic           sw_0,
   uart_word_tx_if.slave bus
);
   localparam int LW       = $clog2(WORD_BYTES + 1);
   localparam int WW       = 8 * WORD_BYTES;
   localparam int CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int SPAN_A   = (STOP_BITS > 8) ? STOP_BITS : 8;
   localparam int BIT_SPAN = (GAP_BITS > SPAN_A) ? GAP_BITS : SPAN_A;
   localparam int BW       = $clog2(BIT_SPAN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_GAP,
      S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] clk_cnt;
   logic [BW-1:0] bit_cnt;
   logic [LW-1:0] bytes_left;
   logic [WW-1:0] word_q;
   logic [7:0]    tx_byte;
   logic          serial_q;
   logic          ready_q;
   logic          busy_q;
   logic          done_q;

   logic          bit_end;
   logic [2:0]    next_idx;
   logic [LW-1:0] len_sat;
   logic [WW-1:0] word_aligned;

   // First byte to send sits in the top slot when the top byte goes first.
   function automatic logic [7:0] head_byte(input logic [WW-1:0] w);
      if (MSB_BYTE_1ST != 0) return w[WW-1 -: 8];
      return w[7:0];
   endfunction

   // Discard the byte just loaded so the next one moves into the head slot.
   function automatic logic [WW-1:0] drop_byte(input logic [WW-1:0] w);
      if (MSB_BYTE_1ST != 0) return w << 8;
      return w >> 8;
   endfunction

   assign bit_end  = (clk_cnt == CW'(CLKS_PER_BIT - 1));
   assign next_idx = bit_cnt[2:0] + 3'd1;

   // Clamp the requested length and, for top-byte-first order, slide byte
   // len-1 up into the head slot so the shifter never has to index.
   always_comb begin
      len_sat      = (bus.i_len > LW'(WORD_BYTES)) ? LW'(WORD_BYTES) : bus.i_len;
      word_aligned = bus.i_word;
      if (MSB_BYTE_1ST != 0)
         word_aligned = bus.i_word << (8 * (WORD_BYTES - int'(len_sat)));
   end

   // Bit-time prescaler: free-runs only while a transfer is in progress.
   always_ff @(posedge sys_clk or negedge sw_0) begin
      if (!sw_0)
         clk_cnt <= '0;
      else if (state == S_IDLE || state == S_DONE || bit_end)
         clk_cnt <= '0;
      else
         clk_cnt <= clk_cnt + CW'(1);
   end

   // Framing state machine with registered line and status outputs; a reset
   // at any point drops the word and returns the line to idle high.
   always_ff @(posedge sys_clk or negedge sw_0) begin
      if (!sw_0) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         bytes_left <= '0;
         word_q     <= '0;
         tx_byte    <= '0;
         serial_q   <= 1'b1;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.i_valid) begin
                  ready_q <= 1'b0;
                  bit_cnt <= '0;
                  if (len_sat == '0) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state      <= S_START;
                     serial_q   <= 1'b0;
                     busy_q     <= 1'b1;
                     tx_byte    <= head_byte(word_aligned);
                     word_q     <= drop_byte(word_aligned);
                     bytes_left <= len_sat - LW'(1);
                  end
               end
            end
            S_START: begin
               if (bit_end) begin
                  state    <= S_DATA;
                  serial_q <= tx_byte[0];
                  bit_cnt  <= '0;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (bit_cnt == BW'(7)) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     state    <= S_PARITY;
                     serial_q <= ^tx_byte;
`else
                     state    <= S_STOP;
                     serial_q <= 1'b1;
`endif
                  end else begin
                     bit_cnt  <= bit_cnt + BW'(1);
                     serial_q <= tx_byte[next_idx];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  state    <= S_STOP;
                  serial_q <= 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (bit_end) begin
                  if (bit_cnt == BW'(STOP_BITS - 1)) begin
                     bit_cnt <= '0;
                     if (bytes_left == '0) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                     end else if (GAP_BITS > 0) begin
                        state <= S_GAP;
                     end else begin
                        state      <= S_START;
                        serial_q   <= 1'b0;
                        tx_byte    <= head_byte(word_q);
                        word_q     <= drop_byte(word_q);
                        bytes_left <= bytes_left - LW'(1);
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end
            S_GAP: begin
               if (bit_end) begin
                  if (bit_cnt == BW'(GAP_BITS - 1)) begin
                     bit_cnt    <= '0;
                     state      <= S_START;
                     serial_q   <= 1'b0;
                     tx_byte    <= head_byte(word_q);
                     word_q     <= drop_byte(word_q);
                     bytes_left <= bytes_left - LW'(1);
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end
            S_DONE: begin
               state   <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state    <= S_IDLE;
               serial_q <= 1'b1;
               ready_q  <= 1'b1;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_serial = serial_q;
   assign bus.o_ready  = ready_q;
   assign bus.o_busy   = busy_q;
   assign bus.o_done   = done_q;
endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: two instances (byte 0 first with no gap, and top
// byte first with a two-bit gap) are driven from a vector table, hand-written
// corner sequences and random words, and checked against a bit-time model of
// the line plus a sampling UART receiver.
module tb_uart_word_tx;
   localparam int CPB  = 4;
   localparam int WB   = 4;
   localparam int GAP1 = 2;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FR = CPB * (10 + PAR);

   logic clk = 1'b0;
   logic sw_0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   uart_word_tx_if #(.WORD_BYTES(WB)) bus0 ();
   uart_word_tx_if #(.WORD_BYTES(WB)) bus1 ();

   uart_word_tx #(
      .CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .STOP_BITS(1), .GAP_BITS(0), .MSB_BYTE_1ST(0)
   ) dut (
      .sys_clk(clk), .sw_0(sw_0), .bus(bus0)
   );

   uart_word_tx #(
      .CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .STOP_BITS(1), .GAP_BITS(GAP1), .MSB_BYTE_1ST(1)
   ) dut_msb (
      .sys_clk(clk), .sw_0(sw_0), .bus(bus1)
   );

   typedef struct {
      int          sel;
      int          len;
      logic [31:0] word;
      int          exp_nbytes;
      logic [7:0]  exp_first;
      int          exp_cycles;
   } vec_t;

   vec_t vecs[7];

   logic cap_serial[$];
   logic cap_busy[$];
   logic cap_ready[$];
   logic cap_done[$];
   int   exp_line[$];
   int   exp_bytes[$];
   int   dec[$];

   function automatic logic getSerial(input int sel);
      return (sel != 0) ? bus1.o_serial : bus0.o_serial;
   endfunction
   function automatic logic getReady(input int sel);
      return (sel != 0) ? bus1.o_ready : bus0.o_ready;
   endfunction
   function automatic logic getBusy(input int sel);
      return (sel != 0) ? bus1.o_busy : bus0.o_busy;
   endfunction
   function automatic logic getDone(input int sel);
      return (sel != 0) ? bus1.o_done : bus0.o_done;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic driveInputs(input int sel, input logic v, input int len, input logic [31:0] w);
      if (sel != 0) begin
         bus1.i_valid = v;
         bus1.i_len   = 3'(len);
         bus1.i_word  = w;
      end else begin
         bus0.i_valid = v;
         bus0.i_len   = 3'(len);
         bus0.i_word  = w;
      end
   endtask

   task automatic sampleOnce(input int sel);
      @(posedge clk);
      #1;
      cap_serial.push_back(getSerial(sel));
      cap_busy.push_back(getBusy(sel));
      cap_ready.push_back(getReady(sel));
      cap_done.push_back(getDone(sel));
   endtask

   // Expected line, one entry per clock, built bit-time by bit-time.
   task automatic modelWord(input int sel, input int len, input logic [31:0] word);
      int n;
      int gap;
      int bits[$];
      logic [7:0] b;
      n   = (len > WB) ? WB : len;
      gap = (sel != 0) ? GAP1 : 0;
      exp_line.delete();
      exp_bytes.delete();
      for (int k = 0; k < n; k++) begin
         int idx;
         idx = (sel != 0) ? (n - 1 - k) : k;
         b   = 8'(word >> (idx * 8));
         exp_bytes.push_back(int'(b));
      end
      for (int k = 0; k < n; k++) begin
         b = 8'(exp_bytes[k]);
         bits.delete();
         bits.push_back(0);
         for (int i = 0; i < 8; i++) bits.push_back(int'(b[i]));
         if (PAR != 0) bits.push_back(int'(^b));
         bits.push_back(1);
         if (k < n - 1)
            for (int g = 0; g < gap; g++) bits.push_back(1);
         foreach (bits[i])
            for (int c = 0; c < CPB; c++) exp_line.push_back(bits[i]);
      end
   endtask

   task automatic applyStimulus(input int sel, input int len, input logic [31:0] word,
                                input bit hold, input bit pre_driven);
      int n;
      int w;
      modelWord(sel, len, word);
      n = exp_line.size();
      cap_serial.delete();
      cap_busy.delete();
      cap_ready.delete();
      cap_done.delete();
      if (!pre_driven) begin
         w = 0;
         while (getReady(sel) !== 1'b1 && w < 2000) begin
            @(posedge clk);
            #1;
            w++;
         end
         if (w >= 2000) checkOutput("ready_timeout", 64'(getReady(sel)), 64'd1);
         driveInputs(sel, 1'b1, len, word);
      end
      @(posedge clk);
      #1;
      driveInputs(sel, hold, len, ~word);
      cap_serial.push_back(getSerial(sel));
      cap_busy.push_back(getBusy(sel));
      cap_ready.push_back(getReady(sel));
      cap_done.push_back(getDone(sel));
      repeat (n + 1) sampleOnce(sel);
   endtask

   task automatic verifyTransaction(input string name);
      int n;
      int bad;
      int ctrl_bad;
      int i;
      logic [7:0] b;
      n        = exp_line.size();
      bad      = 0;
      ctrl_bad = 0;
      for (int k = 0; k < n; k++) begin
         if (cap_serial[k] !== 1'(exp_line[k])) bad++;
         if (cap_busy[k] !== 1'b1 || cap_ready[k] !== 1'b0 || cap_done[k] !== 1'b0) ctrl_bad++;
      end
      checkOutput({name, "_line_errs"}, 64'(bad), 64'd0);
      checkOutput({name, "_ctrl_errs"}, 64'(ctrl_bad), 64'd0);
      checkOutput({name, "_done_cycle"},
                  {60'd0, cap_done[n], cap_busy[n], cap_ready[n], cap_serial[n]}, 64'b1001);
      checkOutput({name, "_ready_back"},
                  {60'd0, cap_done[n+1], cap_busy[n+1], cap_ready[n+1], cap_serial[n+1]}, 64'b0011);
      dec.delete();
      i = 0;
      while (i < cap_serial.size()) begin
         if (cap_serial[i] === 1'b0) begin
            for (int k = 0; k < 8; k++) begin
               int s;
               s = i + CPB * (k + 1) + CPB / 2;
               b[k] = (s < cap_serial.size()) ? cap_serial[s] : 1'b1;
            end
            dec.push_back(int'(b));
            i += CPB * (10 + PAR);
         end else begin
            i++;
         end
      end
      checkOutput({name, "_rx_count"}, 64'(dec.size()), 64'(exp_bytes.size()));
      for (int k = 0; k < dec.size() && k < exp_bytes.size(); k++)
         checkOutput({name, "_rx_byte"}, 64'(dec[k]), 64'(exp_bytes[k]));
   endtask

   function automatic int countOnes(input int which);
      int c;
      c = 0;
      if (which == 0) begin
         foreach (cap_busy[k]) if (cap_busy[k] === 1'b1) c++;
      end else begin
         foreach (cap_done[k]) if (cap_done[k] === 1'b1) c++;
      end
      return c;
   endfunction

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pat[10];
      int bad;
      int sel;
      int len;
      logic [31:0] word;

      vecs[0] = '{0, 1, 32'h000000ab, 1, 8'hab, FR};
      vecs[1] = '{0, 4, 32'h00ff12cd, 4, 8'hcd, 4 * FR};
      vecs[2] = '{1, 4, 32'h00ff12cd, 4, 8'h00, 4 * FR + 3 * GAP1 * CPB};
      vecs[3] = '{0, 0, 32'h12345678, 0, 8'h00, 0};
      vecs[4] = '{0, 7, 32'h00ff12cd, 4, 8'hcd, 4 * FR};
      vecs[5] = '{1, 2, 32'h00ff12cd, 2, 8'h12, 2 * FR + GAP1 * CPB};
      vecs[6] = '{0, 3, 32'ha1b2c3d4, 3, 8'hd4, 3 * FR};
      pat = '{0, 1, 1, 0, 1, 0, 1, 0, 1, 1};

      sw_0 = 1'b0;
      driveInputs(0, 1'b0, 0, 32'h0);
      driveInputs(1, 1'b0, 0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state0", {60'd0, bus0.o_serial, bus0.o_ready, bus0.o_busy, bus0.o_done}, 64'b1100);
      checkOutput("reset_state1", {60'd0, bus1.o_serial, bus1.o_ready, bus1.o_busy, bus1.o_done}, 64'b1100);
      sw_0 = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] table vectors");
      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].sel, vecs[v].len, vecs[v].word, 1'b0, 1'b0);
         verifyTransaction($sformatf("vec%0d", v));
         checkOutput($sformatf("vec%0d_nbytes", v), 64'(dec.size()), 64'(vecs[v].exp_nbytes));
         if (vecs[v].exp_nbytes > 0 && dec.size() > 0)
            checkOutput($sformatf("vec%0d_first", v), 64'(dec[0]), 64'(vecs[v].exp_first));
         checkOutput($sformatf("vec%0d_busy_cycles", v), 64'(countOnes(0)), 64'(vecs[v].exp_cycles));
         checkOutput($sformatf("vec%0d_done_count", v), 64'(countOnes(1)), 64'd1);
      end

      $display("[TB] single byte bit pattern");
      applyStimulus(0, 1, 32'h000000ab, 1'b0, 1'b0);
      bad = 0;
      for (int k = 0; k < 10; k++)
         if (cap_serial[k * CPB + CPB / 2] !== 1'(pat[k])) bad++;
      checkOutput("ab_bit_pattern_errs", 64'(bad), 64'd0);

      $display("[TB] byte 07 frame length and bit after data");
      applyStimulus(0, 1, 32'h00000007, 1'b0, 1'b0);
      checkOutput("b07_bit9", 64'(cap_serial[9 * CPB + CPB / 2]), 64'd1);
      checkOutput("b07_busy_cycles", 64'(countOnes(0)), 64'(FR));

      $display("[TB] valid held while busy");
      applyStimulus(0, 1, 32'h0000005a, 1'b1, 1'b0);
      verifyTransaction("hold_first");
      applyStimulus(0, 1, ~32'h0000005a, 1'b0, 1'b1);
      verifyTransaction("hold_second");
      checkOutput("hold_second_byte", (dec.size() > 0) ? 64'(dec[0]) : 64'hffff, 64'ha5);
      bad = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (bus0.o_serial !== 1'b1 || bus0.o_ready !== 1'b1) bad++;
      end
      checkOutput("hold_idle_after", 64'(bad), 64'd0);

      $display("[TB] reset during second byte");
      driveInputs(0, 1'b1, 4, 32'h00ff12cd);
      @(posedge clk);
      #1;
      driveInputs(0, 1'b0, 4, 32'h0);
      repeat (FR + 6) begin
         @(posedge clk);
         #1;
      end
      checkOutput("rst_pre_serial", 64'(bus0.o_serial), 64'd0);
      sw_0 = 1'b0;
      #1;
      checkOutput("rst_immediate", {60'd0, bus0.o_serial, bus0.o_ready, bus0.o_busy, bus0.o_done}, 64'b1100);
      bad = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (bus0.o_done !== 1'b0) bad++;
      end
      sw_0 = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (bus0.o_done !== 1'b0 || bus0.o_serial !== 1'b1 || bus0.o_ready !== 1'b1) bad++;
      end
      checkOutput("rst_quiet_after", 64'(bad), 64'd0);
      applyStimulus(0, 1, 32'h000000ab, 1'b0, 1'b0);
      verifyTransaction("rst_new_word");

      $display("[TB] random words");
      for (int r = 0; r < 24; r++) begin
         sel  = int'($urandom_range(0, 1));
         len  = int'($urandom_range(0, 7));
         word = $urandom;
         applyStimulus(sel, len, word, 1'b0, 1'b0);
         verifyTransaction($sformatf("rand%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
